// File: rtl/sobol_gen.sv
// ============================================================================
// sobol_gen
// ----------------------------------------------------------------------------
// Single-dimension Sobol low-discrepancy sequence generator.
//
// The generator emits uniform samples u in (0,1) as Q11.21 fixed point, one
// per cycle. It feeds the valid_in/u_in inputs of the inverse-CDF stage.
//
// Gray-code ordering is used, so each new point costs one XOR with a
// direction number:
//   x_i = x_{i-1} ^ v[c]
// where c is the index of the lowest zero bit of (i-1), and x_0 = 0.
//
// Index 0 (u = 0) is never emitted. Every run starts at index 1, which keeps
// ln(0) out of the downstream pipeline.
//
// Parameters
//   WIDTH       output word width (matches the project FP_WIDTH, 32)
//   QFRAC       fractional bits of u_out (matches the project FP_QFRAC, 21)
//   SOBOL_BITS  state / direction-number width; must be <= QFRAC
//
// Ports
//   clk         clock
//   rst_n       synchronous active-low reset
//   start       begin a run (sampled only in IDLE)
//   n_points    sample count for the run (sampled with start)
//   dir_we      direction-number write strobe (honoured only in IDLE)
//   dir_addr    direction-number index k; addresses >= SOBOL_BITS are dropped
//   dir_data    value of v[k]; the MSB has weight 0.5
//   ready_in    downstream accept
//   valid_out   u_out holds a valid sample
//   u_out       Q11.21 sample; the integer bits are always 0
//   busy        high while a run is in progress
//   done        one-cycle pulse after the final transfer of a run
//
// Optional feature: SOBOL_DIGITAL_SHIFT_EN
//   When the macro is defined, two inputs are added:
//     shift_we    shift register write strobe (honoured only in IDLE)
//     shift_data  digital-shift value
//   The shift is XORed into x on the output path only. The recurrence itself
//   is unaffected. A non-zero shift can produce u = 0; clamping that case is
//   left to the downstream stage.
//   Without the macro, the ports are absent and u_out is taken from x
//   directly.
// ============================================================================
module sobol_gen #(
    parameter int WIDTH      = 32,
    parameter int QFRAC      = 21,
    parameter int SOBOL_BITS = QFRAC
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [31:0]                   n_points,
    input  logic                          dir_we,
    input  logic [$clog2(SOBOL_BITS)-1:0] dir_addr,
    input  logic [SOBOL_BITS-1:0]         dir_data,
    input  logic                          ready_in,
`ifdef SOBOL_DIGITAL_SHIFT_EN
    input  logic                          shift_we,
    input  logic [SOBOL_BITS-1:0]         shift_data,
`endif
    output logic                          valid_out,
    output logic [WIDTH-1:0]              u_out,
    output logic                          busy,
    output logic                          done
);

    localparam int AW = $clog2(SOBOL_BITS);

    // Left shift that aligns the SOBOL_BITS-wide state to the Q.QFRAC output.
    localparam int OUT_SHIFT = QFRAC - SOBOL_BITS;

    // The longest run that visits every non-zero index exactly once.
    localparam logic [31:0] RUN_MAX = 32'((64'd1 << SOBOL_BITS) - 64'd1);

    localparam logic [AW:0] V_COUNT = (AW + 1)'(SOBOL_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SOBOL_BITS-1:0]   x_q, x_d;
    logic [SOBOL_BITS-1:0]   i_q, i_d;
    logic [31:0]             rem_q, rem_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [WIDTH-1:0]        u_q, u_d;
    logic [SOBOL_BITS-1:0]   v_q [SOBOL_BITS];
    logic [SOBOL_BITS-1:0]   shift_nxt;
    logic                    dir_wr_ok;
    logic                    xfer;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Clamp the requested count so that a run never wraps back to index 0.
    function automatic logic [31:0] sat_run_len(input logic [31:0] n);
        return (n > RUN_MAX) ? RUN_MAX : n;
    endfunction

    // Index of the lowest zero bit. This is a priority encoder: scanning from
    // the top down means the lowest zero bit is the last one written.
    function automatic logic [AW-1:0] lowest_zero(input logic [SOBOL_BITS-1:0] val);
        logic [AW-1:0] idx;
        idx = '0;
        for (int k = SOBOL_BITS - 1; k >= 0; k--) begin
            if (!val[k]) begin
                idx = AW'(k);
            end
        end
        return idx;
    endfunction

    // Van der Corput direction numbers: v[k] = 1 << (SOBOL_BITS-1-k).
    function automatic logic [SOBOL_BITS-1:0] default_dir(input int k);
        return SOBOL_BITS'(1) << (SOBOL_BITS - 1 - k);
    endfunction

    // Zero-extend the state and align it to the Q.QFRAC output format.
    function automatic logic [WIDTH-1:0] to_fixed(input logic [SOBOL_BITS-1:0] val);
        return WIDTH'(val) << OUT_SHIFT;
    endfunction

    assign dir_wr_ok = (state_q == IDLE) && dir_we && ({1'b0, dir_addr} < V_COUNT);
    assign xfer      = valid_q && ready_in;

    // ------------------------------------------------------------------
    // Optional digital shift
    // ------------------------------------------------------------------
`ifdef SOBOL_DIGITAL_SHIFT_EN
    logic [SOBOL_BITS-1:0] shift_q;

    // The new value is visible to the output mux in the cycle it is written.
    assign shift_nxt = ((state_q == IDLE) && shift_we) ? shift_data : shift_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_nxt;
        end
    end
`else
    assign shift_nxt = '0;
`endif

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        i_d     = i_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    if (n_points != 32'd0) begin
                        state_d = RUN;
                        rem_d   = sat_run_len(n_points);
                        // v_q is read before any same-cycle write lands.
                        x_d     = v_q[0];
                        i_d     = SOBOL_BITS'(1);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            RUN: begin
                if (xfer) begin
                    rem_d = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        x_d = x_q ^ v_q[lowest_zero(i_q)];
                        i_d = i_q + SOBOL_BITS'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // The output register follows x, so u_out holds under backpressure.
        u_d = to_fixed(x_d ^ shift_nxt);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            i_q     <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            u_q     <= '0;
            for (int k = 0; k < SOBOL_BITS; k++) begin
                v_q[k] <= default_dir(k);
            end
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            i_q     <= i_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            u_q     <= u_d;
            if (dir_wr_ok) begin
                v_q[dir_addr] <= dir_data;
            end
        end
    end

    assign valid_out = valid_q;
    assign u_out     = u_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sobol_gen.sv
module tb_sobol_gen;

    localparam int SSB = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] n_points;
    logic        dir_we;
    logic [4:0]  dir_addr;
    logic [20:0] dir_data;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] u_out;
    logic        busy;
    logic        done;
`ifdef SOBOL_DIGITAL_SHIFT_EN
    logic        shift_we;
    logic [20:0] shift_data;
    logic        s_shift_we;
    logic [7:0]  s_shift_data;
`endif

    // Second instance with a narrow state, used to exercise the saturated
    // full-period run in a few hundred cycles.
    logic        s_start;
    logic [31:0] s_n_points;
    logic        s_dir_we;
    logic [2:0]  s_dir_addr;
    logic [7:0]  s_dir_data;
    logic        s_ready;
    logic        s_valid;
    logic [31:0] s_u;
    logic        s_busy;
    logic        s_done;

    always #5 clk = ~clk;

    sobol_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_points  (n_points),
        .dir_we    (dir_we),
        .dir_addr  (dir_addr),
        .dir_data  (dir_data),
        .ready_in  (ready_in),
`ifdef SOBOL_DIGITAL_SHIFT_EN
        .shift_we  (shift_we),
        .shift_data(shift_data),
`endif
        .valid_out (valid_out),
        .u_out     (u_out),
        .busy      (busy),
        .done      (done)
    );

    sobol_gen #(.WIDTH(32), .QFRAC(21), .SOBOL_BITS(SSB)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s_start),
        .n_points  (s_n_points),
        .dir_we    (s_dir_we),
        .dir_addr  (s_dir_addr),
        .dir_data  (s_dir_data),
        .ready_in  (s_ready),
`ifdef SOBOL_DIGITAL_SHIFT_EN
        .shift_we  (s_shift_we),
        .shift_data(s_shift_data),
`endif
        .valid_out (s_valid),
        .u_out     (s_u),
        .busy      (s_busy),
        .done      (s_done)
    );

    // Van der Corput points in Gray-code order, as Q11.21:
    // 1/2, 3/4, 1/4, 3/8, 7/8, 5/8, 1/8, 3/16.
    localparam logic [31:0] GOLD [8] = '{
        32'h0010_0000, 32'h0018_0000, 32'h0008_0000, 32'h000C_0000,
        32'h001C_0000, 32'h0014_0000, 32'h0004_0000, 32'h0006_0000
    };

    int          checks = 0;
    int          errors = 0;
    int          xfers  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_mon;
    logic [255:0] s_seen = '0;
    int          s_count = 0;
    logic [31:0] s_x;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Scoreboard monitor: pops one expected value per transfer.
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_in) begin
            xfers++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got 0x%08h, required no sample", u_out);
            end else begin
                exp_mon = exp_q.pop_front();
                check("sample", u_out, exp_mon);
            end
        end
    end

    // Narrow-instance monitor: every sample must be non-zero, in range and
    // not seen before in this run.
    always @(negedge clk) begin
        if (rst_n && s_valid && s_ready) begin
            s_x = s_u >> (21 - SSB);
            checks++;
            if (s_x == 0 || s_x > 255 || s_u[12:0] != 0 || s_seen[s_x[7:0]]) begin
                errors++;
                $display("FAIL narrow_sample: got 0x%08h, required non-zero unseen point", s_u);
            end
            s_seen[s_x[7:0]] = 1'b1;
            s_count++;
        end
    end

    task automatic push_gold(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(GOLD[k]);
    endtask

    task automatic apply_start(input logic [31:0] n);
        @(posedge clk); #1;
        start    = 1'b1;
        n_points = n;
        @(posedge clk); #1;
        start    = 1'b0;
        n_points = '0;
    endtask

    task automatic write_dir(input logic [4:0] a, input logic [20:0] d);
        @(posedge clk); #1;
        dir_we   = 1'b1;
        dir_addr = a;
        dir_data = d;
        @(posedge clk); #1;
        dir_we   = 1'b0;
    endtask

    // Counts falling edges until done is seen; -1 if the budget runs out.
    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic check_done_pulse(input string name, input int cyc, input int req);
        check({name, "_done_latency"}, cyc, req);
        check({name, "_valid_at_done"}, {31'b0, valid_out}, 32'd0);
        check({name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        @(negedge clk);
        check({name, "_done_width"}, {31'b0, done}, 32'd0);
        check({name, "_queue_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int x0;
        int dcnt;

        rst_n = 1'b0; start = 1'b0; n_points = '0; dir_we = 1'b0;
        dir_addr = '0; dir_data = '0; ready_in = 1'b1;
        s_start = 1'b0; s_n_points = '0; s_dir_we = 1'b0;
        s_dir_addr = '0; s_dir_data = '0; s_ready = 1'b1;
`ifdef SOBOL_DIGITAL_SHIFT_EN
        shift_we = 1'b0; shift_data = '0; s_shift_we = 1'b0; s_shift_data = '0;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'b0, valid_out}, 32'd0);
        check("rst_u", u_out, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic 4-point run, no bubbles
        push_gold(4);
        apply_start(4);
        @(negedge clk);
        check("run4_busy", {31'b0, busy}, 32'd1);
        wait_done(19, c);
        check_done_pulse("run4", c + 1, 5);

        // Backpressure: second sample held for 3 cycles
        push_gold(4);
        x0 = xfers;
        apply_start(4);
        @(posedge clk); #1;
        ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_u", u_out, GOLD[1]);
            check("bp_hold_valid", {31'b0, valid_out}, 32'd1);
        end
        @(posedge clk); #1;
        ready_in = 1'b1;
        wait_done(30, c);
        check_done_pulse("bp", c, 4);
        check("bp_sample_count", xfers - x0, 32'd4);

        // Zero-length run
        apply_start(0);
        wait_done(5, c);
        check_done_pulse("zero", c, 1);

        // Direction-number write, then a single point
        write_dir(5'd0, 21'h0F_FFFF);
        exp_q.push_back(32'h000F_FFFF);
        apply_start(1);
        wait_done(10, c);
        check_done_pulse("dir_write", c, 2);
        write_dir(5'd0, 21'h10_0000);

        // Write together with start: x1 uses the old v[0], x3 the new one
        exp_q.push_back(32'h0010_0000);
        exp_q.push_back(32'h0018_0000);
        exp_q.push_back(32'h0017_FFFF);
        @(posedge clk); #1;
        start = 1'b1; n_points = 32'd3;
        dir_we = 1'b1; dir_addr = 5'd0; dir_data = 21'h0F_FFFF;
        @(posedge clk); #1;
        start = 1'b0; n_points = '0; dir_we = 1'b0;
        wait_done(20, c);
        check_done_pulse("same_cycle_write", c, 4);
        write_dir(5'd0, 21'h10_0000);

        // Mid-run dir_we and start are ignored
        push_gold(8);
        apply_start(8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        dir_we = 1'b1; dir_addr = 5'd1; dir_data = 21'h1F_FFFF;
        start = 1'b1; n_points = 32'd2;
        @(posedge clk); #1;
        dir_we = 1'b0; start = 1'b0; n_points = '0;
        wait_done(30, c);
        check_done_pulse("ignore_midrun", c, 6);

        // Reset mid-run: no done, v back to defaults
        write_dir(5'd2, 21'h00_0001);
        push_gold(2);
        apply_start(8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_valid", {31'b0, valid_out}, 32'd0);
        check("midrst_u", u_out, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("midrst_no_done", dcnt, 32'd0);
        check("midrst_queue", exp_q.size(), 32'd0);
        push_gold(4);
        apply_start(4);
        wait_done(20, c);
        check_done_pulse("after_rst", c, 5);

`ifdef SOBOL_DIGITAL_SHIFT_EN
        // Digital shift on the output only
        @(posedge clk); #1;
        shift_we = 1'b1; shift_data = 21'h08_0000;
        @(posedge clk); #1;
        shift_we = 1'b0;
        exp_q.push_back(32'h0018_0000);
        exp_q.push_back(32'h0010_0000);
        apply_start(2);
        wait_done(10, c);
        check_done_pulse("shift", c, 3);
`endif

        // Saturated run on the narrow instance: 2^8-1 distinct points
        @(posedge clk); #1;
        s_start = 1'b1; s_n_points = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        s_start = 1'b0; s_n_points = '0;
        c = -1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (s_done) begin
                c = k;
                break;
            end
        end
        check("narrow_done_latency", c, 32'd256);
        check("narrow_count", s_count, 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobol_gen.md
# sobol_gen

Single-dimension Sobol low-discrepancy sequence generator. It produces uniform samples u in (0,1) as Q11.21 fixed-point, one per cycle, and sits directly upstream of the inverse-CDF stage, feeding its `valid_in`/`u_in`. It uses Gray-code ordering, so each point costs one XOR with a direction number. Index 0 (u = 0) is never emitted, which keeps ln(0) out of the downstream pipeline.

## Interface
- `WIDTH`, default `fpga_cfg_pkg::FP_WIDTH` (32): output word width.
- `QFRAC`, default `fpga_cfg_pkg::FP_QFRAC` (21): fractional bits of `u_out`.
- `SOBOL_BITS`, default `QFRAC`: state and direction-number width; must be ≤ `QFRAC`.
- Reset and clock: reset `rst_n`, synchronous, active-low; clock `clk`.
- `clk`  in  1: clock.
- `rst_n`  in  1: synchronous active-low reset.
- `start`  in  1: begin a run; sampled only in IDLE.
- `n_points`  in  32: number of samples for the run; sampled with `start`.
- `dir_we`  in  1: direction-number write strobe; honoured only in IDLE.
- `dir_addr`  in  $clog2(SOBOL_BITS): direction-number index k.
- `dir_data`  in  SOBOL_BITS: value of v[k]; MSB weight is 0.5.
- `ready_in`  in  1: downstream accept.
- `valid_out`  out  1: `u_out` holds a valid sample.
- `u_out`  out  WIDTH: Q11.21 sample in (0,1); integer bits are always 0.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse at the end of a run.

## Operation
- State: `x` (SOBOL_BITS), index `i` (SOBOL_BITS), remaining count `rem` (32), direction RAM `v[0..SOBOL_BITS-1]`.
- Reset/default direction numbers: v[k] = 1 << (SOBOL_BITS-1-k), which is the van der Corput dimension.
- Step rule: x_i = x_{i-1} XOR v[c], where c is the index of the lowest zero bit of (i-1), and x_0 = 0.
- Output mapping: `u_out` = zero-extend(x) << (QFRAC-SOBOL_BITS).
- FSM states:
  - IDLE: `start`=1 with `n_points`≠0 → RUN. Load `rem` = min(`n_points`, 2^SOBOL_BITS−1), set x = v[0], i = 1, `valid_out` = 1.
  - IDLE: `start`=1 with `n_points`=0 → DONE.
  - RUN: on each transfer (`valid_out` && `ready_in`), decrement `rem`. If `rem` was 1 → DONE with `valid_out` = 0. Otherwise advance to x_{i+1}, i+1 and keep `valid_out` = 1.
  - DONE: `done` = 1 for exactly one cycle, then → IDLE.
- `start` in RUN or DONE is ignored.
- `dir_we` outside IDLE is ignored, and `v` is unchanged.
- A `dir_we` in the same cycle as an accepted `start` takes effect; x = v[0] uses the old v[0].
- Every new run restarts at index 1. Runs do not resume.
- Backpressure: while `valid_out` && !`ready_in`, `u_out`, `x`, `i` and `rem` hold.
- `dir_addr` ≥ SOBOL_BITS: the write is dropped.

## Timing
- All outputs are registered.
- Reset values: `valid_out`=0, `u_out`=0, `busy`=0, `done`=0. FSM goes to IDLE, `x`/`i`/`rem` are cleared, and `v` returns to defaults.
- `start` accepted at edge T: first sample is visible after T (`valid_out`=1). With `ready_in` held at 1, it sustains one sample per cycle with no bubbles.
- `done` pulses the cycle after the final transfer. `valid_out` and `busy` fall on that same edge.
- The earliest next `start` is sampled the cycle after `done`.
- Reset asserted mid-run: on the next edge all state returns to reset values. A partial run produces no `done`.
- The critical path is lowest-zero-detect on i followed by a mux of v and the XOR. It must close in one cycle at SOBOL_BITS=21.

## Configuration
- Macro: `SOBOL_DIGITAL_SHIFT_EN`.
- With the macro defined:
  - Adds input `shift_we` (1) and input `shift_data` (SOBOL_BITS), both honoured only in IDLE.
  - A `shift` register, reset to 0, is XORed into `x` at the output only: `u_out` = (x XOR shift) zero-extended and shifted. The recurrence is unaffected.
  - A non-zero shift can yield u = 0. The downstream stage clamps this; this block does not.
- Without the macro: the ports are absent and `u_out` comes from `x` directly. Behaviour is identical to shift = 0.

## Test plan
- Default v, `n_points`=4, `ready_in`=1 → `u_out` = 0x00100000, 0x00180000, 0x00080000, 0x000C0000 on consecutive cycles. `done` pulses one cycle after the last sample.
- Same run with `ready_in` low for 3 cycles after the second sample → 0x00180000 is held stable for 3 cycles, and the sequence and sample count are unchanged.
- `n_points`=0 → no `valid_out`, `done` pulses one cycle after `start`. `n_points`=0xFFFFFFFF → exactly 2^21−1 samples, all distinct and non-zero.
- Write v[0]=0x0FFFFF in IDLE, then run `n_points`=1 → `u_out`=0x000FFFFF. A `dir_we` and a `start` issued mid-run are both ignored, and the output matches the golden sequence.
- Reset asserted after 2 samples of an 8-point run → outputs go to 0, no `done`. A new 4-point run reproduces the first test exactly.
- With `SOBOL_DIGITAL_SHIFT_EN`, shift=0x080000, `n_points`=2 → `u_out` = 0x00180000, 0x00100000.
